// File: rtl/alu_op_decoder.sv
// RV32I decode stage: registers one instruction and presents it as an ALU
// command with funct, operand selects, register indices, immediate and flags.
package ALUFuncts;
  typedef enum logic [3:0] {
    ADD  = 4'd0, SUB = 4'd1, SLL = 4'd2, SLT = 4'd3, SLTU = 4'd4,
    XOR  = 4'd5, SRL = 4'd6, SRA = 4'd7, OR  = 4'd8, AND  = 4'd9
  } Type;
endpackage

module alu_op_decoder #(
  parameter int                XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_inst,
  input  logic [XLEN-1:0]      in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output ALUFuncts::Type       out_funct,
  output logic [1:0]           out_op1_sel,
  output logic                 out_op2_sel,
  output logic [4:0]           out_rs1,
  output logic [4:0]           out_rs2,
  output logic [4:0]           out_rd,
  output logic [XLEN-1:0]      out_imm,
  output logic                 out_rd_we,
  output logic                 out_is_branch,
  output logic                 out_illegal,
  output logic [XLEN-1:0]      out_pc
);
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [1:0] SEL1_RS1  = 2'd0;
  localparam logic [1:0] SEL1_PC   = 2'd1;
  localparam logic [1:0] SEL1_ZERO = 2'd2;

  // Base ALU op for a funct3 when funct7 carries no modifier (shared by OP and OP-IMM).
  function automatic ALUFuncts::Type f3_to_funct(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALUFuncts::ADD;
      3'b001:  return ALUFuncts::SLL;
      3'b010:  return ALUFuncts::SLT;
      3'b011:  return ALUFuncts::SLTU;
      3'b100:  return ALUFuncts::XOR;
      3'b101:  return ALUFuncts::SRL;
      3'b110:  return ALUFuncts::OR;
      default: return ALUFuncts::AND;
    endcase
  endfunction

  logic [6:0]      w_opcode;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [31:0]     w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_shamt;
  ALUFuncts::Type  w_funct;
  logic [1:0]      w_op1_sel;
  logic            w_op2_sel;
  logic [31:0]     w_imm;
  logic            w_rd_we;
  logic            w_is_branch;
  logic            w_illegal;
  logic            w_accept;

  assign w_opcode = in_inst[6:0];
  assign w_f3     = in_inst[14:12];
  assign w_f7     = in_inst[31:25];
  assign w_imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
  assign w_imm_s  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign w_imm_b  = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign w_imm_u  = {in_inst[31:12], 12'b0};
  assign w_imm_j  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
  assign w_shamt  = {27'b0, in_inst[24:20]};

  // Opcodes all end in 2'b11, so a bad inst[1:0] falls through to the default arm.
  always_comb begin
    w_funct     = ALUFuncts::ADD;
    w_op1_sel   = SEL1_RS1;
    w_op2_sel   = 1'b0;
    w_imm       = 32'b0;
    w_rd_we     = 1'b0;
    w_is_branch = 1'b0;
    w_illegal   = 1'b0;
    case (w_opcode)
      OPC_OP: begin
        w_rd_we = 1'b1;
        if (w_f7 == 7'b0000000)                         w_funct = f3_to_funct(w_f3);
        else if (w_f7 == 7'b0100000 && w_f3 == 3'b000)  w_funct = ALUFuncts::SUB;
        else if (w_f7 == 7'b0100000 && w_f3 == 3'b101)  w_funct = ALUFuncts::SRA;
        else                                            w_illegal = 1'b1;
      end
      OPC_OPIMM: begin
        w_op2_sel = 1'b1;
        w_rd_we   = 1'b1;
        w_imm     = w_imm_i;
        w_funct   = f3_to_funct(w_f3);
        if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
          w_imm = w_shamt;
          if (w_f3 == 3'b101 && w_f7 == 7'b0100000) w_funct = ALUFuncts::SRA;
          else if (w_f7 != 7'b0000000)              w_illegal = 1'b1;
        end
      end
      OPC_LUI: begin
        w_op1_sel = SEL1_ZERO;
        w_op2_sel = 1'b1;
        w_imm     = w_imm_u;
        w_rd_we   = 1'b1;
      end
      OPC_AUIPC: begin
        w_op1_sel = SEL1_PC;
        w_op2_sel = 1'b1;
        w_imm     = w_imm_u;
        w_rd_we   = 1'b1;
      end
      OPC_JAL: begin
        w_op1_sel = SEL1_PC;
        w_op2_sel = 1'b1;
        w_imm     = w_imm_j;
        w_rd_we   = 1'b1;
      end
      OPC_JALR: begin
        w_op2_sel = 1'b1;
        w_imm     = w_imm_i;
        w_rd_we   = 1'b1;
        w_illegal = (w_f3 != 3'b000);
      end
      OPC_BRANCH: begin
        w_imm       = w_imm_b;
        w_is_branch = 1'b1;
        case (w_f3[2:1])
          2'b00:   w_funct = ALUFuncts::SUB;
          2'b10:   w_funct = ALUFuncts::SLT;
          2'b11:   w_funct = ALUFuncts::SLTU;
          default: w_illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        w_op2_sel = 1'b1;
        w_imm     = w_imm_i;
        w_rd_we   = 1'b1;
      end
      OPC_STORE: begin
        w_op2_sel = 1'b1;
        w_imm     = w_imm_s;
      end
      default: w_illegal = 1'b1;
    endcase
    // An illegal entry must never write a register or redirect flow.
    if (w_illegal) begin
      w_funct     = ALUFuncts::ADD;
      w_op1_sel   = SEL1_RS1;
      w_op2_sel   = 1'b0;
      w_imm       = 32'b0;
      w_rd_we     = 1'b0;
      w_is_branch = 1'b0;
    end
  end

  // Handshake: a side transfers on a clock edge where its valid and ready are both 1;
  // the producer holds valid and payload stable until that edge.
  logic            r_valid;
  ALUFuncts::Type  r_funct;
  logic [1:0]      r_op1_sel;
  logic            r_op2_sel;
  logic [4:0]      r_rs1, r_rs2, r_rd;
  logic [XLEN-1:0] r_imm;
  logic            r_rd_we, r_is_branch, r_illegal;
  logic [XLEN-1:0] r_pc;

  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_funct     <= ALUFuncts::ADD;
      r_op1_sel   <= 2'd0;
      r_op2_sel   <= 1'b0;
      r_rs1       <= 5'd0;
      r_rs2       <= 5'd0;
      r_rd        <= 5'd0;
      r_imm       <= '0;
      r_rd_we     <= 1'b0;
      r_is_branch <= 1'b0;
      r_illegal   <= 1'b0;
      r_pc        <= RESET_PC;
    end else begin
      if (flush)          r_valid <= 1'b0;
      else if (w_accept)  r_valid <= 1'b1;
      else if (out_ready) r_valid <= 1'b0;
      if (w_accept && !flush) begin
        r_funct     <= w_funct;
        r_op1_sel   <= w_op1_sel;
        r_op2_sel   <= w_op2_sel;
        r_rs1       <= in_inst[19:15];
        r_rs2       <= in_inst[24:20];
        r_rd        <= in_inst[11:7];
        r_imm       <= w_imm;
        r_rd_we     <= w_rd_we;
        r_is_branch <= w_is_branch;
        r_illegal   <= w_illegal;
        r_pc        <= in_pc;
      end
    end
  end

  assign out_valid     = r_valid;
  assign out_funct     = r_funct;
  assign out_op1_sel   = r_op1_sel;
  assign out_op2_sel   = r_op2_sel;
  assign out_rs1       = r_rs1;
  assign out_rs2       = r_rs2;
  assign out_rd        = r_rd;
  assign out_imm       = r_imm;
  assign out_rd_we     = r_rd_we;
  assign out_is_branch = r_is_branch;
  assign out_illegal   = r_illegal;
  assign out_pc        = r_pc;
endmodule

// File: tb/tb_alu_op_decoder.sv
// Bench for alu_op_decoder: directed decode/handshake cases, then random traffic
// scored against an instruction-level reference decoder.
module tb_alu_op_decoder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  ALUFuncts::Type out_funct;
  logic [1:0]  out_op1_sel;
  logic        out_op2_sel;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [31:0] out_imm;
  logic        out_rd_we, out_is_branch, out_illegal;
  logic [31:0] out_pc;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];

  alu_op_decoder #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_funct(out_funct),
    .out_op1_sel(out_op1_sel), .out_op2_sel(out_op2_sel),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
    .out_rd_we(out_rd_we), .out_is_branch(out_is_branch),
    .out_illegal(out_illegal), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    ALUFuncts::Type funct;
    logic [1:0]     op1;
    logic           op2;
    logic [31:0]    imm;
    logic           we;
    logic           br;
    logic           ill;
    logic           chk_imm;
  } exp_t;

  ALUFuncts::Type alu_tbl [8] = '{ALUFuncts::ADD, ALUFuncts::SLL, ALUFuncts::SLT, ALUFuncts::SLTU,
                                  ALUFuncts::XOR, ALUFuncts::SRL, ALUFuncts::OR,  ALUFuncts::AND};

  // Two's-complement value of an n-bit field, via plain integer arithmetic.
  function automatic int sext(input int v, input int bits);
    return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] inst);
    exp_t e;
    int   f3, f7, imm_i;
    e = '0;
    e.funct = ALUFuncts::ADD;
    f3 = int'(inst[14:12]);
    f7 = int'(inst[31:25]);
    imm_i = sext(int'(inst[31:20]), 12);
    case (inst[6:0])
      7'h33: begin
        e.we = 1'b1;
        if (f7 == 0) e.funct = alu_tbl[f3];
        else if (f7 == 32 && f3 == 0) e.funct = ALUFuncts::SUB;
        else if (f7 == 32 && f3 == 5) e.funct = ALUFuncts::SRA;
        else e.ill = 1'b1;
      end
      7'h13: begin
        e.op2 = 1'b1; e.we = 1'b1; e.chk_imm = 1'b1;
        if (f3 == 1 || f3 == 5) begin
          e.imm = 32'(int'(inst[24:20]));
          if (f7 == 0) e.funct = alu_tbl[f3];
          else if (f3 == 5 && f7 == 32) e.funct = ALUFuncts::SRA;
          else e.ill = 1'b1;
        end else begin
          e.funct = alu_tbl[f3];
          e.imm = 32'(imm_i);
        end
      end
      7'h37, 7'h17: begin
        e.op1 = (inst[5]) ? 2'd2 : 2'd1;
        e.op2 = 1'b1; e.we = 1'b1; e.chk_imm = 1'b1;
        e.imm = 32'(int'(inst[31:12]) * 4096);
      end
      7'h6F: begin
        e.op1 = 2'd1; e.op2 = 1'b1; e.we = 1'b1; e.chk_imm = 1'b1;
        e.imm = 32'(sext(int'(inst[31]) * (1 << 20) + int'(inst[19:12]) * (1 << 12)
                         + int'(inst[20]) * (1 << 11) + int'(inst[30:21]) * 2, 21));
      end
      7'h67: begin
        e.op2 = 1'b1; e.we = 1'b1; e.chk_imm = 1'b1; e.imm = 32'(imm_i);
        e.ill = (f3 != 0);
      end
      7'h63: begin
        e.br = 1'b1; e.chk_imm = 1'b1;
        e.imm = 32'(sext(int'(inst[31]) * 4096 + int'(inst[7]) * 2048
                         + int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2, 13));
        if (f3 == 0 || f3 == 1) e.funct = ALUFuncts::SUB;
        else if (f3 == 4 || f3 == 5) e.funct = ALUFuncts::SLT;
        else if (f3 == 6 || f3 == 7) e.funct = ALUFuncts::SLTU;
        else e.ill = 1'b1;
      end
      7'h03: begin
        e.op2 = 1'b1; e.we = 1'b1; e.chk_imm = 1'b1; e.imm = 32'(imm_i);
      end
      7'h23: begin
        e.op2 = 1'b1; e.chk_imm = 1'b1;
        e.imm = 32'(sext(int'(inst[31:25]) * 32 + int'(inst[11:7]), 12));
      end
      default: e.ill = 1'b1;
    endcase
    if (e.ill) begin
      e.funct = ALUFuncts::ADD; e.we = 1'b0; e.br = 1'b0; e.chk_imm = 1'b0;
    end
    return e;
  endfunction

  task automatic compare_entry(input logic [63:0] ent);
    exp_t e;
    e = ref_decode(ent[31:0]);
    check("pc",       out_pc,                ent[63:32]);
    check("rd",       32'(out_rd),           32'(ent[11:7]));
    check("rs1",      32'(out_rs1),          32'(ent[19:15]));
    check("rs2",      32'(out_rs2),          32'(ent[24:20]));
    check("illegal",  32'(out_illegal),      32'(e.ill));
    check("rd_we",    32'(out_rd_we),        32'(e.we));
    check("is_br",    32'(out_is_branch),    32'(e.br));
    check("funct",    32'(out_funct),        32'(e.funct));
    if (!e.ill) begin
      check("op1_sel", 32'(out_op1_sel), 32'(e.op1));
      check("op2_sel", 32'(out_op2_sel), 32'(e.op2));
    end
    if (e.chk_imm) check("imm", out_imm, e.imm);
  endtask

  // Scoreboard: queue holds the entry the decoder should be presenting.
  always @(negedge clk) begin
    logic exp_rdy;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      exp_rdy = (exp_q.size() == 0) || out_ready;
      check("in_ready",  32'(in_ready),  32'(exp_rdy));
      check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        compare_entry(exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
      if (flush) exp_q.delete();
      if (in_valid && exp_rdy && !flush) exp_q.push_back({in_pc, in_inst});
    end
  end

  task automatic send(input logic [31:0] inst, input logic [31:0] pc);
    in_valid = 1'b1; in_inst = inst; in_pc = pc;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0]  opc_tbl [9] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23};
    logic [31:0] inst;
    int k, r;
    inst = $urandom;
    k = $urandom_range(0, 9);
    if (k < 9) inst[6:0] = opc_tbl[k];
    r = $urandom_range(0, 3);
    if (r < 2) inst[31:25] = 7'h00;
    else if (r == 2) inst[31:25] = 7'h20;
    return inst;
  endfunction

  initial begin
    logic taken;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_funct", 32'(out_funct), 32'(ALUFuncts::ADD));
    check("rst_pc",    out_pc, 32'h0000_0000);
    check("rst_imm",   out_imm, 32'd0);
    check("rst_we",    32'(out_rd_we), 32'd0);
    check("rst_ill",   32'(out_illegal), 32'd0);
    check("rst_sel",   32'({out_op1_sel, out_op2_sel}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(32'h0050_0093, 32'h0000_0010);   // ADDI x1,x0,5
    check("addi_valid", 32'(out_valid), 32'd1);
    check("addi_funct", 32'(out_funct), 32'(ALUFuncts::ADD));
    check("addi_op1",   32'(out_op1_sel), 32'd0);
    check("addi_op2",   32'(out_op2_sel), 32'd1);
    check("addi_imm",   out_imm, 32'd5);
    check("addi_rd",    32'(out_rd), 32'd1);
    check("addi_we",    32'(out_rd_we), 32'd1);

    send(32'h4020_81B3, 32'h0000_0014);   // SUB x3,x1,x2
    check("sub_funct", 32'(out_funct), 32'(ALUFuncts::SUB));
    check("sub_rs1",   32'(out_rs1), 32'd1);
    check("sub_rs2",   32'(out_rs2), 32'd2);
    check("sub_rd",    32'(out_rd), 32'd3);
    send(32'h4030_D213, 32'h0000_0018);   // SRAI x4,x1,3
    check("srai_funct", 32'(out_funct), 32'(ALUFuncts::SRA));
    check("srai_imm",   out_imm, 32'd3);

    send(32'h1234_52B7, 32'h0000_001C);   // LUI x5,0x12345
    check("lui_op1", 32'(out_op1_sel), 32'd2);
    check("lui_imm", out_imm, 32'h1234_5000);
    send(32'h0020_E463, 32'h0000_0020);   // BLTU x1,x2,+8
    check("bltu_funct", 32'(out_funct), 32'(ALUFuncts::SLTU));
    check("bltu_br",    32'(out_is_branch), 32'd1);
    check("bltu_imm",   out_imm, 32'd8);
    check("bltu_we",    32'(out_rd_we), 32'd0);

    send(32'hFFFF_FFFF, 32'h0000_0024);
    check("ones_ill", 32'(out_illegal), 32'd1);
    check("ones_we",  32'(out_rd_we), 32'd0);
    send(32'h0210_9093, 32'h0000_0028);   // SLLI with imm[11:5]=0000001
    check("slli_ill", 32'(out_illegal), 32'd1);
    check("slli_we",  32'(out_rd_we), 32'd0);
    @(posedge clk); #1;

    // Stall with a second instruction waiting, then release with no bubble.
    out_ready = 1'b0;
    send(32'h0050_0093, 32'h0000_0100);
    in_valid = 1'b1; in_inst = 32'h4020_81B3; in_pc = 32'h0000_0104;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_ready", 32'(in_ready), 32'd0);
      check("stall_pc",    out_pc, 32'h0000_0100);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("release_valid", 32'(out_valid), 32'd1);
    check("release_pc",    out_pc, 32'h0000_0104);
    @(posedge clk); #1;

    // Flush a stalled entry, then flush while a new instruction is accepted.
    out_ready = 1'b0;
    send(32'h0050_0093, 32'h0000_0200);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_stall", 32'(out_valid), 32'd0);
    out_ready = 1'b1; flush = 1'b1;
    send(32'h0050_0093, 32'h0000_0300);
    flush = 1'b0;
    check("flush_accept", 32'(out_valid), 32'd0);

    // Asynchronous reset while stalled.
    out_ready = 1'b0;
    send(32'h1234_52B7, 32'h0000_0400);
    #2 rst_n = 1'b0;
    #1;
    check("areset_valid", 32'(out_valid), 32'd0);
    check("areset_pc",    out_pc, 32'h0000_0000);
    check("areset_funct", 32'(out_funct), 32'(ALUFuncts::ADD));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      taken = in_valid && in_ready;
      @(posedge clk); #1;
      if (!in_valid || taken) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_inst  = rand_inst();
        in_pc    = $urandom & 32'hFFFF_FFFC;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
